sensor_timing_gen: RTL and testbench
====================================

# sensor_timing_gen

Image-sensor emulation stage that consumes the divided 5 MHz pixel clock and produces one frame of sensor-style video timing per start request. The frame carries frame_valid, line_valid and a selectable test-pattern pixel bus. The block runs entirely in the system clock domain and uses the 5 MHz clock only as a sampled signal whose rising edges act as pixel ticks. It drives the capture/checker logic of the sensor test bench.

## Interface
- H_ACTIVE, 16, active pixels per line (≥2)
- H_BLANK, 4, blank pixel ticks after each line (≥1)
- V_ACTIVE, 8, active lines per frame (≥2)
- V_BLANK, 2, ticks with frame_valid low after the last line (≥1)
- FRONT, 2, ticks with frame_valid high before the first line (≥1)
- DATA_W, 10, pixel data width (≥2)
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- clk_5mhz  input  1  divided clock from the divider stage; sampled as data, never used as a clock
- start  input  1  single-cycle frame request
- pattern_sel  input  2  0 = horizontal ramp, 1 = vertical ramp, 2 = checkerboard, 3 = constant
- busy  output  1  frame armed or in progress
- frame_valid  output  1  high from FRONT_PORCH through the last HBLANK tick
- line_valid  output  1  high during active pixels only
- pix_data  output  DATA_W  pixel value; valid while line_valid = 1
- pix_x  output  clog2(H_ACTIVE)  column index of the current pixel
- pix_y  output  clog2(V_ACTIVE)  line index
- pix_tick  output  1  one-clk strobe marking the first cycle of new output values
- frame_done  output  1  one-clk pulse at the end of VBLANK

## Operation
- Edge detect: clk_5mhz_d <= clk_5mhz; tick = clk_5mhz & ~clk_5mhz_d. clk_5mhz_d resets to 1 so there is no false tick out of reset.
- Arming: when start = 1 in IDLE and not armed, set armed, set busy, and latch pattern_sel.
  - start is ignored while armed or busy.
  - Changing pattern_sel after the latch has no effect until the next frame.
- FSM states: IDLE, FRONT_PORCH, LINE, HBLANK, VBLANK. Transitions occur only on clk edges where tick = 1.
- IDLE → FRONT_PORCH on a tick with armed = 1. Clear armed, set frame_valid = 1.
- FRONT_PORCH: counts FRONT ticks, then → LINE with line_valid = 1, pix_x = 0 and pix_y = 0.
- LINE: pix_x increments each tick.
  - After pix_x = H_ACTIVE-1 → HBLANK, line_valid = 0.
- HBLANK: counts H_BLANK ticks.
  - If pix_y < V_ACTIVE-1: increment pix_y, reset pix_x to 0, → LINE.
  - Otherwise → VBLANK with frame_valid = 0.
- VBLANK: counts V_BLANK ticks, then → IDLE. On that tick frame_done pulses and busy falls.
- Pixel value, computed from the next pix_x/pix_y and registered with them:
  - Horizontal ramp: pix_x zero-extended to DATA_W.
  - Vertical ramp: pix_y zero-extended to DATA_W.
  - Checkerboard: all ones if pix_x[0]^pix_y[0], else 0.
  - Constant: alternating 1010… pattern, MSB = 1.
- pix_data is forced to 0 whenever line_valid = 0.
- Reset, including mid-frame, takes effect immediately:
  - FSM returns to IDLE; armed is cleared.
  - All outputs go to 0: busy, frame_valid, line_valid, pix_data, pix_x, pix_y, pix_tick, frame_done.
  - No partial frame resumes after reset.

## Timing
- The divider toggles every 10 clk cycles, so a tick occurs every 20 clk cycles.
- All outputs are registered.
- pix_tick is a registered copy of tick. It is high exactly in the first clk cycle where the updated outputs are visible.
- busy rises one clk after start. The frame begins on the first tick after that.
- Frame length is FRONT + V_ACTIVE·(H_ACTIVE+H_BLANK) + V_BLANK ticks. With defaults this is 164 ticks = 3280 clk cycles.
- line_valid is high for exactly H_ACTIVE ticks per line, V_ACTIVE times per frame.
- frame_done is high for 1 clk, coincident with pix_tick, and in the same cycle busy falls to 0.
- A start in the same cycle as the frame_done pulse is ignored. A start one cycle later is accepted.
- Back-to-back frames therefore have at least 1 idle tick between frame_valid falling and the next FRONT_PORCH.

## Test plan
- Reset hold with clk_5mhz toggling: all outputs stay 0. Release rst_n while clk_5mhz = 1 → no pix_tick before the next true rising edge.
- start with pattern_sel = 0, default parameters:
  - 8 lines of 16 pixels each; pix_data = 0..15 on every line.
  - frame_valid high for 162 ticks.
  - frame_done exactly once, 164 ticks after frame start.
- pattern_sel = 2 → pixel (0,0) = 0x000 and pixel (1,0) = 0x3FF. pattern_sel = 3 → every active pixel = 0x2AA.
- start pulses while busy, plus pattern_sel changed mid-frame → frame length and pattern are unchanged, and no second frame starts.
- rst_n asserted during line 3, pixel 7 → outputs go to 0 asynchronously. After release, a new start produces a full frame from pix_y = 0.
- clk_5mhz held constant after start → block stays armed, busy = 1, frame_valid = 0 until toggling resumes.

Source files
------------

// File: rtl/sensor_timing_gen.sv
// rtl/sensor_timing_gen.sv - sensor-style frame timing and test-pattern generator paced by sampled 5 MHz ticks
module sensor_timing_gen #(
    parameter int H_ACTIVE = 16,
    parameter int H_BLANK  = 4,
    parameter int V_ACTIVE = 8,
    parameter int V_BLANK  = 2,
    parameter int FRONT    = 2,
    parameter int DATA_W   = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_5mhz,
    input  logic                        start,
    input  logic [1:0]                  pattern_sel,
    output logic                        busy,
    output logic                        frame_valid,
    output logic                        line_valid,
    output logic [DATA_W-1:0]           pix_data,
    output logic [$clog2(H_ACTIVE)-1:0] pix_x,
    output logic [$clog2(V_ACTIVE)-1:0] pix_y,
    output logic                        pix_tick,
    output logic                        frame_done
);

    localparam int XW   = $clog2(H_ACTIVE);
    localparam int YW   = $clog2(V_ACTIVE);
    localparam int CMAX = ((FRONT > H_BLANK ? FRONT : H_BLANK) > V_BLANK) ?
                          (FRONT > H_BLANK ? FRONT : H_BLANK) : V_BLANK;
    localparam int CW   = $clog2(CMAX) + 1;

    // Alternating 1010... word with the MSB set, used by the constant pattern.
    function automatic logic [DATA_W-1:0] alt_word();
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DATA_W; i++) begin
            v[i] = ((DATA_W - 1 - i) % 2 == 0);
        end
        return v;
    endfunction

    localparam logic [DATA_W-1:0] ALT = alt_word();

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRONT,
        S_LINE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        pat_q, pat_d;
    logic              clk5_q;
    logic              armed_q, armed_d;
    logic              busy_q, busy_d;
    logic              fv_q, fv_d;
    logic              lv_q, lv_d;
    logic              done_q, done_d;
    logic              ptick_q;
    logic              tick;

    // Rising edge of the sampled divider clock; clk5_q resets high so reset release never fakes a tick.
    assign tick = clk_5mhz & ~clk5_q;

    // Next-state logic: arming on start, frame sequencing on ticks, pixel value from next coordinates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        pat_d   = pat_q;
        armed_d = armed_q;
        busy_d  = busy_q;
        fv_d    = fv_q;
        lv_d    = lv_q;
        done_d  = 1'b0;
        data_d  = '0;

        // A start landing on the frame_done cycle is dropped so frames never abut.
        if (start && (state_q == S_IDLE) && !armed_q && !busy_q && !done_q) begin
            armed_d = 1'b1;
            busy_d  = 1'b1;
            pat_d   = pattern_sel;
        end

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q) begin
                        armed_d = 1'b0;
                        fv_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_FRONT;
                    end
                end
                S_FRONT: begin
                    if (cnt_q == CW'(FRONT - 1)) begin
                        state_d = S_LINE;
                        lv_d    = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_LINE: begin
                    if (x_q == XW'(H_ACTIVE - 1)) begin
                        state_d = S_HBLANK;
                        lv_d    = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                S_HBLANK: begin
                    if (cnt_q == CW'(H_BLANK - 1)) begin
                        cnt_d = '0;
                        if (y_q != YW'(V_ACTIVE - 1)) begin
                            y_d     = y_q + 1'b1;
                            x_d     = '0;
                            lv_d    = 1'b1;
                            state_d = S_LINE;
                        end else begin
                            fv_d    = 1'b0;
                            state_d = S_VBLANK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_VBLANK: begin
                    if (cnt_q == CW'(V_BLANK - 1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (lv_d) begin
            case (pat_q)
                2'd0:    data_d = DATA_W'(x_d);
                2'd1:    data_d = DATA_W'(y_d);
                2'd2:    data_d = {DATA_W{x_d[0] ^ y_d[0]}};
                default: data_d = ALT;
            endcase
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            pat_q   <= '0;
            clk5_q  <= 1'b1;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            done_q  <= 1'b0;
            ptick_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            pat_q   <= pat_d;
            clk5_q  <= clk_5mhz;
            armed_q <= armed_d;
            busy_q  <= busy_d;
            fv_q    <= fv_d;
            lv_q    <= lv_d;
            done_q  <= done_d;
            ptick_q <= tick;
        end
    end

    assign busy        = busy_q;
    assign frame_valid = fv_q;
    assign line_valid  = lv_q;
    assign pix_data    = data_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign pix_tick    = ptick_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_sensor_timing_gen.sv
// tb/tb_sensor_timing_gen.sv - directed self-checking bench for sensor_timing_gen
module tb_sensor_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_5mhz = 1'b0;
    logic       start = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       busy, frame_valid, line_valid, pix_tick, frame_done;
    logic [9:0] pix_data;
    logic [3:0] pix_x;
    logic [2:0] pix_y;

    bit div_en = 1'b1;
    int div_cnt = 0;
    int n_assert = 0;
    int n_fail = 0;

    sensor_timing_gen #(
        .H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(8), .V_BLANK(2), .FRONT(2), .DATA_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_5mhz(clk_5mhz), .start(start),
        .pattern_sel(pattern_sel), .busy(busy), .frame_valid(frame_valid),
        .line_valid(line_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_tick(pix_tick), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Divider emulation: toggle every 10 clk cycles, away from the sampling edge.
    always @(negedge clk) begin
        if (div_en) begin
            if (div_cnt == 9) begin
                div_cnt  <= 0;
                clk_5mhz <= ~clk_5mhz;
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] exp_pix(input logic [1:0] pat, input int x, input int y);
        case (pat)
            2'd0:    return 10'(x);
            2'd1:    return 10'(y);
            2'd2:    return ((x ^ y) & 1) != 0 ? 10'h3FF : 10'h000;
            default: return 10'h2AA;
        endcase
    endfunction

    task automatic run_frame(input logic [1:0] pat, input bit issue_start,
                             input bit disturb, input bit b2b);
        int pix_cnt = 0, lines = 0, fv_ticks = 0, done_at = -1, tick_idx = 0;
        bit started = 0, prev_lv = 0, done_seen = 0, bad = 0;
        logic [9:0] exp_d;
        if (issue_start) begin
            pattern_sel = pat;
            start = 1'b1;
            cyc();
            start = 1'b0;
            n_assert++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_rise: busy=%b required 1", busy);
            end
        end
        for (int c = 0; c < 4000 && !done_seen; c++) begin
            cyc();
            if (disturb) begin
                start = (c == 400 || c == 1600);
                if (c == 800) pattern_sel = ~pat;
            end
            if (!started && frame_valid) begin
                started = 1;
                n_assert++;
                if (pix_tick !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fv_rise_tick: pix_tick=%b required 1", pix_tick);
                end
            end else if (started && pix_tick) begin
                tick_idx++;
            end
            if (pix_tick && frame_valid) fv_ticks++;
            if (line_valid && !prev_lv) lines++;
            prev_lv = line_valid;
            if (pix_tick && line_valid) begin
                exp_d = exp_pix(pat, pix_cnt % 16, pix_cnt / 16);
                n_assert++;
                if (pix_x !== 4'(pix_cnt % 16) || pix_y !== 3'(pix_cnt / 16) || pix_data !== exp_d) begin
                    n_fail++;
                    $display("FAIL pixel %0d: x=%0d y=%0d data=%h required x=%0d y=%0d data=%h",
                             pix_cnt, pix_x, pix_y, pix_data, pix_cnt % 16, pix_cnt / 16, exp_d);
                end
                pix_cnt++;
            end
            if (!line_valid && pix_data !== 10'h000) bad = 1;
            if (frame_done) begin
                done_seen = 1;
                done_at = tick_idx;
                n_assert++;
                if (pix_tick !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_coincide: pix_tick=%b busy=%b required 1 and 0", pix_tick, busy);
                end
                if (b2b) start = 1'b1;
            end
        end
        if (disturb) start = 1'b0;
        n_assert++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL frame_timeout: frame_done seen=%b required 1", done_seen);
        end
        n_assert++;
        if (bad) begin
            n_fail++;
            $display("FAIL blank_data: nonzero pix_data with line_valid=0, required 0");
        end
        n_assert++;
        if (pix_cnt != 128 || lines != 8) begin
            n_fail++;
            $display("FAIL active_count: pixels=%0d lines=%0d required 128 and 8", pix_cnt, lines);
        end
        n_assert++;
        if (fv_ticks != 162) begin
            n_fail++;
            $display("FAIL fv_length: %0d ticks required 162", fv_ticks);
        end
        n_assert++;
        if (done_at != 164) begin
            n_fail++;
            $display("FAIL frame_length: done at tick %0d required 164", done_at);
        end
        if (b2b) begin
            cyc();
            n_assert++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_on_done: busy=%b required 0", busy);
            end
            pattern_sel = 2'd1;
            cyc();
            start = 1'b0;
            n_assert++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL start_after_done: busy=%b required 1", busy);
            end
        end else begin
            bad = 0;
            for (int c = 0; c < 200; c++) begin
                cyc();
                if (busy !== 1'b0 || frame_valid !== 1'b0 || frame_done !== 1'b0) bad = 1;
            end
            n_assert++;
            if (bad) begin
                n_fail++;
                $display("FAIL no_second_frame: busy/frame_valid/frame_done active after frame, required 0");
            end
        end
    endtask

    task automatic test_reset();
        bit bad = 0;
        logic prev;
        int ticks = 0;
        rst_n = 1'b0;
        for (int c = 0; c < 60; c++) begin
            cyc();
            if ({busy, frame_valid, line_valid, pix_tick, frame_done} !== 5'b0 ||
                pix_data !== 10'h000 || pix_x !== 4'h0 || pix_y !== 3'h0) bad = 1;
        end
        n_assert++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_hold: outputs busy=%b fv=%b lv=%b tick=%b done=%b data=%h required all 0",
                     busy, frame_valid, line_valid, pix_tick, frame_done, pix_data);
        end
        prev = clk_5mhz;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (clk_5mhz && !prev) break;
            prev = clk_5mhz;
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            cyc();
            if (pix_tick) ticks++;
        end
        n_assert++;
        if (ticks != 0) begin
            n_fail++;
            $display("FAIL reset_release_tick: %0d pix_tick before next rising edge, required 0", ticks);
        end
        ticks = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (pix_tick) ticks++;
        end
        n_assert++;
        if (ticks != 1) begin
            n_fail++;
            $display("FAIL first_tick: %0d pix_tick in window, required 1", ticks);
        end
    endtask

    task automatic test_hramp();
        run_frame(2'd0, 1, 0, 0);
    endtask

    task automatic test_checker();
        run_frame(2'd2, 1, 0, 0);
    endtask

    task automatic test_disturb_const();
        run_frame(2'd3, 1, 1, 0);
    endtask

    task automatic test_midframe_reset();
        bit found = 0, bad = 0;
        pattern_sel = 2'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if (line_valid && pix_y == 3'd3 && pix_x == 4'd7) begin
                found = 1;
                break;
            end
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_line3_pix7: found=%b required 1", found);
        end
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if ({busy, frame_valid, line_valid, pix_tick, frame_done} !== 5'b0 ||
            pix_data !== 10'h000 || pix_x !== 4'h0 || pix_y !== 3'h0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b fv=%b lv=%b data=%h x=%0d y=%0d required all 0",
                     busy, frame_valid, line_valid, pix_data, pix_x, pix_y);
        end
        for (int c = 0; c < 5; c++) cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (busy !== 1'b0 || frame_valid !== 1'b0) bad = 1;
        end
        n_assert++;
        if (bad) begin
            n_fail++;
            $display("FAIL no_resume: frame activity after reset release, required none");
        end
        run_frame(2'd0, 1, 0, 0);
    endtask

    task automatic test_stall();
        bit bad = 0;
        div_en = 1'b0;
        pattern_sel = 2'd3;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            cyc();
            if (busy !== 1'b1 || frame_valid !== 1'b0 || pix_tick !== 1'b0) bad = 1;
        end
        n_assert++;
        if (bad) begin
            n_fail++;
            $display("FAIL stall: busy=%b fv=%b tick=%b required 1, 0, 0", busy, frame_valid, pix_tick);
        end
        div_en = 1'b1;
        run_frame(2'd3, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_frame(2'd0, 1, 0, 1);
        run_frame(2'd1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_hramp();
        test_checker();
        test_disturb_const();
        test_midframe_reset();
        test_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
